// File: rtl/spi_slave_rx.sv
// SPI slave, modes 0-3: MOSI deserialiser plus a one-word buffered MISO serialiser.
// Latency: SCLK/SS edge acts 3 i_sys_clk later; o_tx_ready stays low while the TX buffer is full.
module spi_slave_rx #(
  parameter int DATA_SIZE = 16
) (
  input  logic                 i_sys_clk,
  input  logic                 i_sys_rst,
  input  logic                 i_cpol,
  input  logic                 i_cpha,
  input  logic                 i_sclk,
  input  logic                 i_ss_n,
  input  logic                 i_mosi,
  output logic                 o_miso,
  output logic                 o_miso_oe,
  input  logic [DATA_SIZE-1:0] i_tx_data,
  input  logic                 i_tx_valid,
  output logic                 o_tx_ready,
  output logic [DATA_SIZE-1:0] o_rx_data,
  output logic                 o_rx_valid,
  output logic                 o_tx_underrun,
  output logic                 o_frame_abort,
  output logic                 o_busy
);

  localparam int CNT_W = $clog2(DATA_SIZE + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_SIZE - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state_q, state_d;

  logic sclk_s1, sclk_s2, sclk_s3;
  logic ss_s1, ss_s2, ss_s3;
  logic mosi_s1, mosi_s2;

  logic sclk_rise, sclk_fall, ss_fall, ss_rise;
  logic lead_edge, trail_edge, sample_edge, shift_edge;
  logic frame_start, frame_end, sample_en, shift_en;
  logic tx_load, tx_wr;

  logic                 cpol_q, cpha_q;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 load_pending;
  logic [DATA_SIZE-1:0] rx_shift, tx_shift, tx_buf, rx_data_q;
  logic                 tx_empty_q, rx_valid_q, underrun_q, abort_q;

  // SS flops reset low so an SS still held low at reset release cannot look like a new frame.
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_s3 <= 1'b0;
      ss_s1   <= 1'b0;
      ss_s2   <= 1'b0;
      ss_s3   <= 1'b0;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      sclk_s1 <= i_sclk;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      ss_s1   <= i_ss_n;
      ss_s2   <= ss_s1;
      ss_s3   <= ss_s2;
      mosi_s1 <= i_mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  assign sclk_rise   = sclk_s2 & ~sclk_s3;
  assign sclk_fall   = ~sclk_s2 & sclk_s3;
  assign ss_fall     = ~ss_s2 & ss_s3;
  assign ss_rise     = ss_s2 & ~ss_s3;
  assign lead_edge   = cpol_q ? sclk_fall : sclk_rise;
  assign trail_edge  = cpol_q ? sclk_rise : sclk_fall;
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign shift_edge  = cpha_q ? lead_edge : trail_edge;

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    sample_en   = 1'b0;
    shift_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d     = ACTIVE;
          frame_start = 1'b1;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          state_d   = IDLE;
          frame_end = 1'b1;
        end else begin
          sample_en = sample_edge;
          shift_en  = shift_edge;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_load = frame_start | (shift_en & load_pending);
  assign tx_wr   = i_tx_valid & tx_empty_q;

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      cpol_q       <= 1'b0;
      cpha_q       <= 1'b0;
      bit_cnt      <= '0;
      load_pending <= 1'b0;
      rx_shift     <= '0;
      tx_shift     <= '0;
      tx_buf       <= '0;
      rx_data_q    <= '0;
      tx_empty_q   <= 1'b1;
      rx_valid_q   <= 1'b0;
      underrun_q   <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      abort_q    <= 1'b0;

      if (frame_start) begin
        cpol_q       <= i_cpol;
        cpha_q       <= i_cpha;
        bit_cnt      <= '0;
        load_pending <= 1'b0;
      end

      if (frame_end) begin
        abort_q      <= (bit_cnt != '0);
        bit_cnt      <= '0;
        load_pending <= 1'b0;
      end

      if (sample_en) begin
        rx_shift <= {rx_shift[DATA_SIZE-2:0], mosi_s2};
        if (bit_cnt == LAST_BIT) begin
          rx_data_q    <= {rx_shift[DATA_SIZE-2:0], mosi_s2};
          rx_valid_q   <= 1'b1;
          bit_cnt      <= '0;
          load_pending <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end

      // A load in the same cycle as a write sees the buffer empty; the write lands below.
      if (tx_load) begin
        load_pending <= 1'b0;
        tx_empty_q   <= 1'b1;
        if (tx_empty_q) begin
          tx_shift   <= '0;
          underrun_q <= 1'b1;
        end else begin
          tx_shift <= tx_buf;
        end
      end else if (shift_en && bit_cnt != '0) begin
        tx_shift <= {tx_shift[DATA_SIZE-2:0], 1'b0};
      end

      if (tx_wr) begin
        tx_buf     <= i_tx_data;
        tx_empty_q <= 1'b0;
      end
    end
  end

  assign o_busy        = (state_q == ACTIVE);
  assign o_miso_oe     = (state_q == ACTIVE);
  assign o_miso        = (state_q == ACTIVE) & tx_shift[DATA_SIZE-1];
  assign o_tx_ready    = tx_empty_q;
  assign o_rx_data     = rx_data_q;
  assign o_rx_valid    = rx_valid_q;
  assign o_tx_underrun = underrun_q;
  assign o_frame_abort = abort_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: a behavioural SPI master drives frames; a negedge monitor scores
// received words and master-side MISO words against queues filled when each frame is issued.
module tb_spi_slave_rx;

  localparam int DW   = 16;
  localparam int HALF = 80;

  logic          i_sys_clk, i_sys_rst;
  logic          i_cpol, i_cpha, i_sclk, i_ss_n, i_mosi;
  logic          o_miso, o_miso_oe;
  logic [DW-1:0] i_tx_data;
  logic          i_tx_valid, o_tx_ready;
  logic [DW-1:0] o_rx_data;
  logic          o_rx_valid, o_tx_underrun, o_frame_abort, o_busy;

  spi_slave_rx #(.DATA_SIZE(DW)) dut (
    .i_sys_clk     (i_sys_clk),
    .i_sys_rst     (i_sys_rst),
    .i_cpol        (i_cpol),
    .i_cpha        (i_cpha),
    .i_sclk        (i_sclk),
    .i_ss_n        (i_ss_n),
    .i_mosi        (i_mosi),
    .o_miso        (o_miso),
    .o_miso_oe     (o_miso_oe),
    .i_tx_data     (i_tx_data),
    .i_tx_valid    (i_tx_valid),
    .o_tx_ready    (o_tx_ready),
    .o_rx_data     (o_rx_data),
    .o_rx_valid    (o_rx_valid),
    .o_tx_underrun (o_tx_underrun),
    .o_frame_abort (o_frame_abort),
    .o_busy        (o_busy)
  );

  initial i_sys_clk = 1'b0;
  always #5 i_sys_clk = ~i_sys_clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int rxv_cnt = 0;
  int underrun_cnt = 0;
  int abort_cnt = 0;
  int exp_rxv = 0;

  logic [DW-1:0] exp_rx_q[$];
  logic [DW-1:0] exp_miso_q[$];
  logic [DW-1:0] got_miso_q[$];
  logic [DW-1:0] mon_word;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(negedge i_sys_clk) begin
    if (!i_sys_rst) begin
      if (o_tx_underrun) underrun_cnt++;
      if (o_frame_abort) abort_cnt++;
      if (o_rx_valid) begin
        rxv_cnt++;
        if (exp_rx_q.size() == 0) begin
          total_cnt++;
          $display("FAIL rx_word: unexpected o_rx_valid with data 0x%0h", o_rx_data);
        end else begin
          check("rx_word", o_rx_data, exp_rx_q.pop_front());
        end
      end
      if (got_miso_q.size() != 0) begin
        mon_word = got_miso_q.pop_front();
        if (exp_miso_q.size() == 0) begin
          total_cnt++;
          $display("FAIL miso_word: master got 0x%0h with nothing expected", mon_word);
        end else begin
          check("miso_word", mon_word, exp_miso_q.pop_front());
        end
      end
    end
  end

  task automatic tx_write(input logic [DW-1:0] d);
    int t;
    t = 0;
    @(negedge i_sys_clk);
    while (!o_tx_ready && t < 200) begin
      @(negedge i_sys_clk);
      t++;
    end
    if (!o_tx_ready) begin
      total_cnt++;
      $display("FAIL tx_ready_wait: o_tx_ready still 0 after 200 cycles, expected 1");
    end else begin
      i_tx_data  = d;
      i_tx_valid = 1'b1;
      @(negedge i_sys_clk);
      i_tx_valid = 1'b0;
      check("tx_ready_after_write", o_tx_ready, 0);
    end
  endtask

  task automatic frame_begin(input logic pol, input logic pha);
    i_cpol = pol;
    i_cpha = pha;
    i_sclk = pol;
    #200;
    i_ss_n = 1'b0;
    #HALF;
  endtask

  // last: leave SCLK at its active level after the final bit; frame_end returns it to idle after SS.
  task automatic xfer(input logic [DW-1:0] d, input int n, input bit last, input bit record);
    logic [DW-1:0] got;
    got = '0;
    for (int i = 0; i < n; i++) begin
      if (!i_cpha) begin
        i_mosi = d[DW-1-i];
        #HALF;
        i_sclk = ~i_cpol;
        got = {got[DW-2:0], o_miso};
        #HALF;
        if (!(last && i == n - 1)) i_sclk = i_cpol;
      end else begin
        #HALF;
        i_sclk = ~i_cpol;
        i_mosi = d[DW-1-i];
        #HALF;
        i_sclk = i_cpol;
        got = {got[DW-2:0], o_miso};
      end
    end
    if (record) got_miso_q.push_back(got);
  endtask

  task automatic frame_end();
    #HALF;
    i_ss_n = 1'b1;
    #HALF;
    i_sclk = i_cpol;
    #200;
  endtask

  task automatic one_word(input logic pol, input logic pha, input logic [DW-1:0] tx,
                          input logic [DW-1:0] rx);
    tx_write(tx);
    exp_rx_q.push_back(rx);
    exp_miso_q.push_back(tx);
    exp_rxv++;
    frame_begin(pol, pha);
    xfer(rx, DW, 1, 1);
    frame_end();
  endtask

  initial begin
    i_sys_rst  = 1'b1;
    i_cpol     = 1'b0;
    i_cpha     = 1'b0;
    i_sclk     = 1'b0;
    i_ss_n     = 1'b1;
    i_mosi     = 1'b0;
    i_tx_data  = '0;
    i_tx_valid = 1'b0;
    repeat (4) @(negedge i_sys_clk);
    check("rst_tx_ready", o_tx_ready, 1);
    check("rst_busy", o_busy, 0);
    check("rst_miso_oe", o_miso_oe, 0);
    check("rst_rx_data", o_rx_data, 0);
    i_sys_rst = 1'b0;
    repeat (10) @(negedge i_sys_clk);
    check("idle_busy", o_busy, 0);

    // Mode 0 single word with activity checks mid-frame
    tx_write(16'hA5C3);
    exp_rx_q.push_back(16'h1234);
    exp_miso_q.push_back(16'hA5C3);
    exp_rxv++;
    frame_begin(1'b0, 1'b0);
    check("active_busy", o_busy, 1);
    check("active_miso_oe", o_miso_oe, 1);
    check("first_miso_bit", o_miso, 1);
    check("tx_ready_after_load", o_tx_ready, 1);
    xfer(16'h1234, DW, 1, 1);
    frame_end();
    check("idle_miso_oe", o_miso_oe, 0);

    one_word(1'b0, 1'b1, 16'h0F0F, 16'hBEEF);
    one_word(1'b1, 1'b0, 16'h0F0F, 16'hBEEF);
    one_word(1'b1, 1'b1, 16'h0F0F, 16'hBEEF);

    // Two back-to-back words in one frame; second TX word written after the first load
    tx_write(16'h1111);
    exp_rx_q.push_back(16'h0001);
    exp_rx_q.push_back(16'h8000);
    exp_miso_q.push_back(16'h1111);
    exp_miso_q.push_back(16'h2222);
    exp_rxv += 2;
    frame_begin(1'b0, 1'b0);
    tx_write(16'h2222);
    xfer(16'h0001, DW, 0, 1);
    xfer(16'h8000, DW, 1, 1);
    frame_end();
    check("underrun_none_yet", underrun_cnt, 0);

    // Empty TX buffer: zeros on MISO, one underrun pulse at SS assert
    exp_rx_q.push_back(16'hFFFF);
    exp_miso_q.push_back(16'h0000);
    exp_rxv++;
    frame_begin(1'b0, 1'b0);
    check("underrun_at_ss", underrun_cnt, 1);
    xfer(16'hFFFF, DW, 1, 1);
    frame_end();
    check("rx_valid_count_a", rxv_cnt, exp_rxv);

    // SS released after 7 bits
    tx_write(16'h3C3C);
    frame_begin(1'b0, 1'b0);
    xfer(16'h5555, 7, 1, 0);
    frame_end();
    check("abort_pulse", abort_cnt, 1);
    check("abort_no_rx_valid", rxv_cnt, exp_rxv);
    check("abort_rx_data_held", o_rx_data, 16'hFFFF);
    one_word(1'b0, 1'b0, 16'h6789, 16'hCAFE);

    // Reset mid-frame after 5 bits, SS still low across release
    tx_write(16'h1357);
    frame_begin(1'b0, 1'b0);
    xfer(16'hABCD, 5, 1, 0);
    @(negedge i_sys_clk);
    i_sys_rst = 1'b1;
    #1;
    check("mid_rst_outputs", {o_miso, o_miso_oe, o_rx_valid, o_tx_underrun, o_frame_abort, o_busy}, 0);
    check("mid_rst_rx_data", o_rx_data, 0);
    check("mid_rst_tx_ready", o_tx_ready, 1);
    repeat (5) @(negedge i_sys_clk);
    i_sys_rst = 1'b0;
    repeat (10) @(negedge i_sys_clk);
    check("post_rst_busy", o_busy, 0);
    frame_end();
    check("post_rst_no_abort", abort_cnt, 1);
    one_word(1'b0, 1'b0, 16'h2468, 16'h9ABC);

    repeat (50) @(negedge i_sys_clk);
    check("final_rx_valid_count", rxv_cnt, exp_rxv);
    check("final_underrun_count", underrun_cnt, 1);
    check("final_abort_count", abort_cnt, 1);
    check("rx_queue_drained", exp_rx_q.size(), 0);
    check("miso_queue_drained", exp_miso_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/spi_slave_rx.md
SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

Interface
REQ-001 The block SHALL have parameter DATA_SIZE, default 16, meaning bits per SPI word (range 2..32).
REQ-002 The block SHALL have port i_sys_clk  input  1  system clock; all logic on its rising edge.
REQ-003 The block SHALL have port i_sys_rst  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have port i_cpol  input  1  SCLK idle level.
REQ-005 The block SHALL have port i_cpha  input  1  0 = sample on leading edge, 1 = sample on trailing edge.
REQ-006 The block SHALL have port i_sclk  input  1  SPI clock from master, asynchronous to i_sys_clk.
REQ-007 The block SHALL have port i_ss_n  input  1  slave select, active-low, asynchronous.
REQ-008 The block SHALL have port i_mosi  input  1  serial data from master, MSB first.
REQ-009 The block SHALL have port o_miso  output  1  serial data to master, MSB first.
REQ-010 The block SHALL have port o_miso_oe  output  1  MISO output enable.
REQ-011 The block SHALL have port i_tx_data  input  DATA_SIZE  next word to transmit.
REQ-012 The block SHALL have port i_tx_valid  input  1  i_tx_data valid.
REQ-013 The block SHALL have port o_tx_ready  output  1  TX buffer empty; write accepted when i_tx_valid & o_tx_ready.
REQ-014 The block SHALL have port o_rx_data  output  DATA_SIZE  last complete received word, held until next word.
REQ-015 The block SHALL have port o_rx_valid  output  1  one-cycle pulse, o_rx_data updated.
REQ-016 The block SHALL have port o_tx_underrun  output  1  one-cycle pulse, word loaded while TX buffer empty.
REQ-017 The block SHALL have port o_frame_abort  output  1  one-cycle pulse, SS deasserted mid-word.
REQ-018 The block SHALL have port o_busy  output  1  high in ACTIVE state.

Function
REQ-019 i_sclk, i_ss_n, i_mosi SHALL pass 2-flop synchronizers; a third SCLK/SS flop SHALL provide edge detection; input-to-edge latency 3 cycles.
REQ-020 Supported SCLK: high and low phases each >= 4 i_sys_clk cycles; faster SCLK is out of scope.
REQ-021 Leading edge = rising if cpol=0, falling if cpol=1; sample edge = leading if cpha=0 else trailing; shift edge = the other.
REQ-022 i_cpol/i_cpha SHALL be latched on synchronized SS falling edge and held for the frame.
REQ-023 FSM states: IDLE, ACTIVE. IDLE->ACTIVE on synced SS falling; ACTIVE->IDLE on synced SS rising.
REQ-024 On IDLE->ACTIVE: bit_cnt=0, load_pending=0, TX shift register loaded from TX buffer (buffer emptied).
REQ-025 Sample edge in ACTIVE: rx_shift <= {rx_shift[DATA_SIZE-2:0], synced MOSI}; bit_cnt++.
REQ-026 When bit_cnt reaches DATA_SIZE: o_rx_data <= completed word, o_rx_valid pulses the next cycle, bit_cnt <= 0, load_pending <= 1.
REQ-027 Shift edge in ACTIVE: if load_pending, load TX shift from buffer and clear load_pending; else if bit_cnt==0, no change; else shift left, LSB fill 0.
REQ-028 Any TX load with buffer empty SHALL load all-zeros and pulse o_tx_underrun one cycle.
REQ-029 TX buffer write and TX load in the same cycle: load sees buffer empty (zeros, underrun); the written word stays buffered for the next load.
REQ-030 o_tx_ready SHALL be registered, 1 when buffer empty, 0 the cycle after an accepted write until the load that empties it.
REQ-031 o_miso = TX shift MSB and o_miso_oe = 1 in ACTIVE; o_miso = 0, o_miso_oe = 0 in IDLE.
REQ-032 SS rising with bit_cnt != 0: discard partial word, no o_rx_valid, o_frame_abort pulses one cycle, load_pending cleared.
REQ-033 SS rising with bit_cnt == 0: no abort pulse; TX buffer content SHALL be retained across frames.
REQ-034 Back-to-back words within one SS frame SHALL be received with no lost bits.
REQ-035 SCLK edges while in IDLE SHALL be ignored.

Reset
REQ-036 On i_sys_rst: state IDLE, TX buffer empty (o_tx_ready=1), shift registers and bit_cnt 0, o_rx_data 0, and o_miso, o_miso_oe, o_rx_valid, o_tx_underrun, o_frame_abort, o_busy all 0.
REQ-037 Reset mid-frame SHALL abort silently, with no pulses; after release the block waits for a fresh SS falling edge.

Verification
REQ-038 Mode 0, DATA_SIZE=16, TX 0xA5C3 preloaded, master sends 0x1234 -> o_rx_data=0x1234 with one o_rx_valid pulse; master receives 0xA5C3.
REQ-039 Modes 1, 2, 3 each: master sends 0xBEEF, TX 0x0F0F -> rx 0xBEEF, master receives 0x0F0F.
REQ-040 Mode 0, one SS frame of two words 0x0001 then 0x8000, TX 0x1111 buffered and 0x2222 written after the first load -> two o_rx_valid pulses; master receives 0x1111 then 0x2222.
REQ-041 No TX write, master sends 0xFFFF -> o_tx_underrun one pulse at SS assert; master receives 0x0000.
REQ-042 SS released after 7 bits -> o_frame_abort pulse, no o_rx_valid, o_rx_data unchanged; next full frame is received correctly.
REQ-043 i_sys_rst asserted after 5 bits -> all outputs 0 and o_tx_ready=1; a subsequent frame completes normally.
